peripheral_msi_slave_port_bb: RTL and testbench

- Per-slave arbitration and multiplexing stage of the MSI AHB-Lite switch; one instance per AHB slave.
- Sits directly downstream of the MSI master ports. It collects each master port's request toward this slave, arbitrates by priority with round-robin tie-break, and returns a registered one-hot master_granted vector to the master ports.
- Drives the selected master's address phase and the data-phase owner's write data onto the slave. Returns slave HRDATA/HREADY/HRESP to all master ports.

---
 rtl/peripheral_msi_slave_port_bb.sv | 125 ++++++++++++
 tb/tb_peripheral_msi_slave_port_bb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_msi_slave_port_bb.sv
// Per-slave stage of the MSI AHB-Lite switch: priority/round-robin arbitration
// across master ports, address/data-phase muxing, and the slave return path.
module peripheral_msi_slave_port_bb #(
  parameter int PLEN    = 64,
  parameter int XLEN    = 64,
  parameter int MASTERS = 5
) (
  input  logic                           HRESETn,
  input  logic                           HCLK,

  input  logic [MASTERS-1:0][2:0]        mst_priority,
  input  logic [MASTERS-1:0]             mst_HSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]   mst_HADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]   mst_HWDATA,
  input  logic [MASTERS-1:0]             mst_HWRITE,
  input  logic [MASTERS-1:0][2:0]        mst_HSIZE,
  input  logic [MASTERS-1:0][2:0]        mst_HBURST,
  input  logic [MASTERS-1:0][3:0]        mst_HPROT,
  input  logic [MASTERS-1:0][1:0]        mst_HTRANS,
  input  logic [MASTERS-1:0]             mst_HMASTLOCK,
  input  logic [MASTERS-1:0]             mst_HREADY,
  input  logic [MASTERS-1:0]             can_switch,

  output logic [MASTERS-1:0]             master_granted,
  output logic [XLEN-1:0]                mst_HRDATA,
  output logic                           mst_HREADYOUT,
  output logic                           mst_HRESP,

  output logic                           slv_HSEL,
  output logic [PLEN-1:0]                slv_HADDR,
  output logic [XLEN-1:0]                slv_HWDATA,
  output logic                           slv_HWRITE,
  output logic [2:0]                     slv_HSIZE,
  output logic [2:0]                     slv_HBURST,
  output logic [3:0]                     slv_HPROT,
  output logic [1:0]                     slv_HTRANS,
  output logic                           slv_HMASTLOCK,
  output logic                           slv_HREADY,
  input  logic [XLEN-1:0]                slv_HRDATA,
  input  logic                           slv_HREADYOUT,
  input  logic                           slv_HRESP
);
  localparam int         MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [1:0] IDLE        = 2'b00;

  logic [MASTERS-1:0]     owner, dp_owner, req, winner;
  logic [MASTER_BITS-1:0] last_idx, owner_idx, win_idx;
  logic                   dp_valid, grant_en, found;
  logic [2:0]             best;
  logic [XLEN-1:0]        wdata_mux;

  assign req = mst_HSEL;

  // Scan starts just past the last winner; strict '>' keeps the first equal-priority hit.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    best    = '0;
    win_idx = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = (int'(last_idx) + k) % MASTERS;
      if (req[idx] && (!found || mst_priority[idx] > best)) begin
        found   = 1'b1;
        best    = mst_priority[idx];
        win_idx = MASTER_BITS'(idx);
      end
    end
    winner = '0;
    if (found) winner[win_idx] = 1'b1;
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < MASTERS; i++)
      if (owner[i]) owner_idx = MASTER_BITS'(i);
  end

  // A locked owner that has not released keeps the bus even if it drops HSEL.
  assign grant_en = slv_HREADYOUT
                  & ((|(owner & can_switch)) | ~(|(owner & req)))
                  & ~(|(owner & mst_HMASTLOCK & ~can_switch));

  assign master_granted = owner;

  assign slv_HSEL      = mst_HSEL[owner_idx];
  assign slv_HADDR     = mst_HADDR[owner_idx];
  assign slv_HWRITE    = mst_HWRITE[owner_idx];
  assign slv_HSIZE     = mst_HSIZE[owner_idx];
  assign slv_HBURST    = mst_HBURST[owner_idx];
  assign slv_HPROT     = mst_HPROT[owner_idx];
  assign slv_HMASTLOCK = mst_HMASTLOCK[owner_idx];
  assign slv_HTRANS    = mst_HSEL[owner_idx] ? mst_HTRANS[owner_idx] : IDLE;
  assign slv_HREADY    = dp_valid ? slv_HREADYOUT : mst_HREADY[owner_idx];

  // AND-OR mux so an empty data-phase owner drives zero write data.
  always_comb begin
    wdata_mux = '0;
    for (int i = 0; i < MASTERS; i++)
      if (dp_owner[i]) wdata_mux = wdata_mux | mst_HWDATA[i];
  end
  assign slv_HWDATA = wdata_mux;

  assign mst_HRDATA    = slv_HRDATA;
  assign mst_HREADYOUT = slv_HREADYOUT;
  assign mst_HRESP     = slv_HRESP;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner    <= {{(MASTERS-1){1'b0}}, 1'b1};
      last_idx <= '0;
      dp_owner <= '0;
      dp_valid <= 1'b0;
    end else begin
      if (grant_en && |req) begin
        owner    <= winner;
        last_idx <= win_idx;
      end
      if (slv_HREADY) begin
        dp_valid <= slv_HSEL & (slv_HTRANS != IDLE);
        dp_owner <= owner;
      end
    end
  end
endmodule

// File: tb/tb_peripheral_msi_slave_port_bb.sv
// Directed bench: stimulus schedules expected values per cycle into a
// scoreboard; a negedge monitor pops and compares them.
module tb_peripheral_msi_slave_port_bb;
  localparam int PLEN = 64, XLEN = 64, M = 5;

  logic                    HRESETn, HCLK;
  logic [M-1:0][2:0]       prio;
  logic [M-1:0]            hsel, hwrite, hlock, hready, cs;
  logic [M-1:0][PLEN-1:0]  haddr;
  logic [M-1:0][XLEN-1:0]  hwdata;
  logic [M-1:0][2:0]       hsize, hburst;
  logic [M-1:0][3:0]       hprot;
  logic [M-1:0][1:0]       htrans;
  logic [M-1:0]            granted;
  logic [XLEN-1:0]         m_rdata, s_rdata, s_wdata;
  logic                    m_readyout, m_resp;
  logic                    s_sel, s_write, s_lock, s_ready, s_readyout, s_resp;
  logic [PLEN-1:0]         s_addr;
  logic [2:0]              s_size, s_burst;
  logic [3:0]              s_prot;
  logic [1:0]              s_trans;

  peripheral_msi_slave_port_bb #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .mst_priority(prio), .mst_HSEL(hsel), .mst_HADDR(haddr), .mst_HWDATA(hwdata),
    .mst_HWRITE(hwrite), .mst_HSIZE(hsize), .mst_HBURST(hburst), .mst_HPROT(hprot),
    .mst_HTRANS(htrans), .mst_HMASTLOCK(hlock), .mst_HREADY(hready), .can_switch(cs),
    .master_granted(granted), .mst_HRDATA(m_rdata), .mst_HREADYOUT(m_readyout),
    .mst_HRESP(m_resp),
    .slv_HSEL(s_sel), .slv_HADDR(s_addr), .slv_HWDATA(s_wdata), .slv_HWRITE(s_write),
    .slv_HSIZE(s_size), .slv_HBURST(s_burst), .slv_HPROT(s_prot), .slv_HTRANS(s_trans),
    .slv_HMASTLOCK(s_lock), .slv_HREADY(s_ready), .slv_HRDATA(s_rdata),
    .slv_HREADYOUT(s_readyout), .slv_HRESP(s_resp)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  localparam int S_GNT = 0, S_SEL = 1, S_TRANS = 2, S_ADDR = 3, S_WDATA = 4,
                 S_RESP = 5, S_RDYOUT = 6, S_HREADY = 7, S_RDATA = 8;

  typedef struct {
    string       name;
    int          cyc;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  function automatic logic [63:0] sig(int s);
    case (s)
      S_GNT:    return 64'(granted);
      S_SEL:    return 64'(s_sel);
      S_TRANS:  return 64'(s_trans);
      S_ADDR:   return s_addr;
      S_WDATA:  return s_wdata;
      S_RESP:   return 64'(m_resp);
      S_RDYOUT: return 64'(m_readyout);
      S_HREADY: return 64'(s_ready);
      S_RDATA:  return m_rdata;
      default:  return '0;
    endcase
  endfunction

  always @(negedge HCLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        n_tests++;
        if (sig(sb[i].sel) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, want %h", sb[i].name, cyc, sig(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: check for cyc %0d never sampled", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(string n, int s, logic [63:0] v, int d);
    sb.push_back('{n, cyc + d, s, v});
  endtask

  task automatic req_on(int m, logic [2:0] p, logic [63:0] a, logic [63:0] d);
    hsel[m] = 1'b1; htrans[m] = 2'b10; prio[m] = p; haddr[m] = a; hwdata[m] = d;
  endtask

  task automatic req_off(int m);
    hsel[m] = 1'b0; htrans[m] = 2'b00;
  endtask

  initial begin
    HRESETn = 1'b0;
    prio = '0; hsel = '0; hwrite = '0; hlock = '0; hready = '1; cs = '1;
    haddr = '0; hwdata = '0; hsize = '0; hburst = '0; hprot = '0; htrans = '0;
    s_rdata = 64'hFEED_FACE_0123_4567; s_readyout = 1'b1; s_resp = 1'b0;

    // reset, idle
    tick(); tick();
    chk("rst_gnt", S_GNT, 64'h01, 0);
    chk("rst_hsel", S_SEL, 64'h0, 0);
    chk("rst_htrans", S_TRANS, 64'h0, 0);
    chk("rst_readyout", S_RDYOUT, 64'h1, 0);
    chk("rst_resp", S_RESP, 64'h0, 0);
    chk("rdata_pass", S_RDATA, 64'hFEED_FACE_0123_4567, 0);
    HRESETn = 1'b1;
    chk("post_rst_gnt", S_GNT, 64'h01, 1);
    tick();

    // single requester, one-cycle grant, write data one cycle after address
    tick();
    req_on(2, 3'd1, 64'h0000_2000_0000_0020, 64'hD2D2_D2D2_0000_0002);
    chk("m2_gnt", S_GNT, 64'h04, 1);
    chk("m2_haddr", S_ADDR, 64'h0000_2000_0000_0020, 1);
    chk("m2_hsel", S_SEL, 64'h1, 1);
    chk("m2_htrans", S_TRANS, 64'h2, 1);
    chk("m2_hwdata", S_WDATA, 64'hD2D2_D2D2_0000_0002, 2);
    tick(); tick();
    req_off(2);
    tick();

    // priority win, then round-robin tie-break past last_idx=3
    tick();
    req_on(1, 3'd2, 64'h10, 64'h11);
    req_on(3, 3'd5, 64'h30, 64'h33);
    chk("prio_m3_gnt", S_GNT, 64'h08, 1);
    tick();
    req_off(3);
    req_on(1, 3'd4, 64'h10, 64'h11);
    req_on(4, 3'd4, 64'h40, 64'h44);
    chk("rr_m4_gnt", S_GNT, 64'h10, 1);
    tick();
    req_off(1); req_off(4);
    tick();

    // locked owner holds bus against higher-priority request
    tick();
    req_on(0, 3'd0, 64'h100, 64'h1000);
    hlock[0] = 1'b1; cs[0] = 1'b0;
    chk("lock_m0_gnt", S_GNT, 64'h01, 1);
    tick();
    req_on(1, 3'd7, 64'h110, 64'h1100);
    for (int k = 0; k < 4; k++) chk("lock_hold", S_GNT, 64'h01, k);
    repeat (4) tick();
    cs[0] = 1'b1;
    chk("lock_release_same", S_GNT, 64'h01, 0);
    chk("lock_release_m1", S_GNT, 64'h02, 1);
    tick();
    req_off(0); hlock[0] = 1'b0; req_off(1);
    tick();

    // parked owner zero-latency, then pending switch frozen by wait states
    tick();
    req_on(1, 3'd0, 64'hA1A1, 64'hD1D1_D1D1);
    chk("park_hsel", S_SEL, 64'h1, 0);
    chk("park_haddr", S_ADDR, 64'hA1A1, 0);
    tick();
    req_off(1);
    req_on(3, 3'd3, 64'hA3A3, 64'hD3D3_D3D3);
    s_readyout = 1'b0;
    chk("ws_hready", S_HREADY, 64'h0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("ws_gnt_frozen", S_GNT, 64'h02, k);
      chk("ws_wdata_frozen", S_WDATA, 64'hD1D1_D1D1, k);
    end
    repeat (3) tick();
    s_readyout = 1'b1;
    chk("ws_end_gnt", S_GNT, 64'h02, 0);
    chk("ws_end_wdata", S_WDATA, 64'hD1D1_D1D1, 0);
    chk("ws_switch_m3", S_GNT, 64'h08, 1);
    tick();

    // two-cycle ERROR response, no switch during its first cycle
    tick();
    req_off(3);
    req_on(0, 3'd1, 64'hA0A0, 64'hD0D0);
    s_resp = 1'b1; s_readyout = 1'b0;
    chk("err1_resp", S_RESP, 64'h1, 0);
    chk("err1_readyout", S_RDYOUT, 64'h0, 0);
    chk("err1_gnt", S_GNT, 64'h08, 0);
    tick();
    s_readyout = 1'b1;
    chk("err2_resp", S_RESP, 64'h1, 0);
    chk("err2_gnt", S_GNT, 64'h08, 0);
    chk("err_after_gnt", S_GNT, 64'h01, 1);
    tick();
    s_resp = 1'b0;
    req_off(0);
    req_on(4, 3'd2, 64'hA4A4, 64'hD4D4);
    chk("pre_rst_gnt", S_GNT, 64'h10, 1);
    tick();

    // reset during an active data phase
    tick();
    HRESETn = 1'b0;
    req_off(4);
    hready[0] = 1'b0;
    chk("midrst_gnt", S_GNT, 64'h01, 0);
    chk("midrst_no_dphase", S_HREADY, 64'h0, 0);
    tick();
    HRESETn = 1'b1; hready = '1;
    repeat (3) tick();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
